// File: rtl/prog_instr_memory.sv
// Instruction memory with an asynchronous fetch port and a byte-stream loader that packs
// little-endian words at auto-incrementing addresses while stalling the core.
module prog_instr_memory #(
    parameter int unsigned DEPTH = 64,
    parameter logic [31:0] NOP   = 32'h0000_0013,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [31:0]   i_a,
    output logic [31:0]   o_rd,
    input  logic          i_prog_en,
    input  logic          i_byte_valid,
    input  logic [7:0]    i_byte_data,
    output logic          o_byte_ready,
    output logic          o_prog_busy,
    output logic          o_prog_done,
    output logic          o_prog_err,
    output logic [CW-1:0] o_word_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFault
    } state_e;

    state_e        r_state, w_state_next;
    logic [CW-1:0] r_wptr, w_wptr_next;
    logic [1:0]    r_idx, w_idx_next;
    logic [23:0]   r_shift, w_shift_next;
    logic          r_done, w_done_next;
    logic          r_err, w_err_next;

    logic          w_accept;
    logic          w_we;
    logic [31:0]   w_wdata;
    logic [29:0]   w_word_addr;
    logic          w_in_range;
    logic          w_unused;

    // Not reset: loaded program survives a reset; initial value models power-up contents.
    logic [31:0]   r_mem [DEPTH] = '{default: NOP};

    assign w_word_addr = i_a[31:2];
    assign w_in_range  = (w_word_addr < 30'(DEPTH));
    assign w_unused    = ^i_a[1:0];

    assign o_prog_busy  = (r_state != StIdle);
    assign o_rd         = (w_in_range && !o_prog_busy) ? r_mem[w_word_addr[AW-1:0]] : NOP;
    assign o_byte_ready = (r_state == StLoad) && i_prog_en && (r_wptr < CW'(DEPTH));
    assign o_prog_done  = r_done;
    assign o_prog_err   = r_err;
    assign o_word_count = r_wptr;

    assign w_accept = o_byte_ready && i_byte_valid;
    assign w_we     = w_accept && (r_idx == 2'd3);
    assign w_wdata  = {i_byte_data, r_shift};

    always_comb begin
        w_state_next = r_state;
        w_wptr_next  = r_wptr;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_done_next  = 1'b0;
        w_err_next   = r_err;
        case (r_state)
            StIdle: begin
                if (i_prog_en) begin
                    w_state_next = StLoad;
                    w_wptr_next  = '0;
                    w_idx_next   = '0;
                    w_shift_next = '0;
                    w_err_next   = 1'b0;
                end
            end
            StLoad: begin
                if (!i_prog_en) begin
                    // A partial word at session end is a framing error, not a clean close.
                    w_state_next = StIdle;
                    if (r_idx == 2'd0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end else if (i_byte_valid && (r_wptr == CW'(DEPTH))) begin
                    w_err_next   = 1'b1;
                    w_state_next = StFault;
                end else if (w_accept) begin
                    w_idx_next = 2'(r_idx + 2'd1);
                    case (r_idx)
                        2'd0:    w_shift_next[7:0]   = i_byte_data;
                        2'd1:    w_shift_next[15:8]  = i_byte_data;
                        2'd2:    w_shift_next[23:16] = i_byte_data;
                        default: w_wptr_next         = CW'(r_wptr + 1'b1);
                    endcase
                end
            end
            StFault: begin
                if (!i_prog_en) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_wptr  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_wptr  <= w_wptr_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[r_wptr[AW-1:0]] <= w_wdata;
        end
    end

endmodule

// File: tb/tb_prog_instr_memory.sv
// Directed bench for prog_instr_memory: loader sessions, fetch gating, overflow and reset abort.
module tb_prog_instr_memory;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk;
    logic          rst_n;
    logic [31:0]   a;
    logic [31:0]   rd;
    logic          prog_en;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          prog_busy;
    logic          prog_done;
    logic          prog_err;
    logic [CW-1:0] word_count;

    int n_checks = 0;
    int n_errors = 0;

    prog_instr_memory #(
        .DEPTH (DEPTH),
        .NOP   (NOP),
        .CW    (CW)
    ) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_a          (a),
        .o_rd         (rd),
        .i_prog_en    (prog_en),
        .i_byte_valid (byte_valid),
        .i_byte_data  (byte_data),
        .o_byte_ready (byte_ready),
        .o_prog_busy  (prog_busy),
        .o_prog_done  (prog_done),
        .o_prog_err   (prog_err),
        .o_word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
        end
    endtask

    task automatic fetch(input logic [31:0] addr, output logic [31:0] data);
        a = addr;
        #1;
        data = rd;
    endtask

    // Called at a negedge; returns at a negedge with the session open.
    task automatic start_session();
        prog_en    = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            check("ready_timeout", 32'(byte_ready), 32'd1);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    // Drops PROG_EN and checks the close; returns at a negedge.
    task automatic end_session(input string tag, input logic exp_done, input logic exp_err);
        prog_en    = 1'b0;
        byte_valid = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_done"}, 32'(prog_done), 32'(exp_done));
        check({tag, "_err"}, 32'(prog_err), 32'(exp_err));
        check({tag, "_busy"}, 32'(prog_busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_clr"}, 32'(prog_done), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  t5_bytes [8];

        rst_n      = 1'b0;
        a          = '0;
        prog_en    = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check("rst_busy", 32'(prog_busy), 32'd0);
        check("rst_done", 32'(prog_done), 32'd0);
        check("rst_err", 32'(prog_err), 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_ready", 32'(byte_ready), 32'd0);
        fetch(32'h0, d);
        check("rst_mem0", d, NOP);

        // 1: two clean words
        start_session();
        check("t1_busy", 32'(prog_busy), 32'd1);
        push_byte(8'h93); push_byte(8'h00); push_byte(8'h10); push_byte(8'h00);
        push_byte(8'h37); push_byte(8'h03); push_byte(8'h00); push_byte(8'h80);
        check("t1_count", 32'(word_count), 32'd2);
        fetch(32'h4, d);
        check("t2_stall_nop", d, NOP);
        end_session("t1", 1'b1, 1'b0);
        fetch(32'h0, d);
        check("t1_mem0", d, 32'h0010_0093);
        fetch(32'h4, d);
        check("t1_mem1", d, 32'h8000_0337);
        check("t1_count_hold", 32'(word_count), 32'd2);

        // 2: out-of-range fetch
        fetch(32'h100, d);
        check("t2_oor", d, NOP);
        fetch(32'h103, d);
        check("t2_oor_unaligned", d, NOP);

        // 3: partial word
        start_session();
        push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
        end_session("t3", 1'b0, 1'b1);
        check("t3_count", 32'(word_count), 32'd0);
        fetch(32'h0, d);
        check("t3_mem0", d, 32'h0010_0093);

        // 4: fill memory then overflow
        start_session();
        check("t4_err_clr", 32'(prog_err), 32'd0);
        for (int i = 0; i < 4 * DEPTH; i++) push_byte(8'(i));
        check("t4_count_full", 32'(word_count), DEPTH);
        check("t4_ready_full", 32'(byte_ready), 32'd0);
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        @(posedge clk);
        #1;
        check("t4_ovf_err", 32'(prog_err), 32'd1);
        check("t4_ovf_busy", 32'(prog_busy), 32'd1);
        check("t4_ovf_ready", 32'(byte_ready), 32'd0);
        @(negedge clk);
        end_session("t4", 1'b0, 1'b1);
        for (int k = 0; k < DEPTH; k++) begin
            fetch(32'(4 * k), d);
            check("t4_mem", d, {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)});
        end

        // 5: valid toggling with gaps
        t5_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
        start_session();
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                @(negedge clk);
            end
            push_byte(t5_bytes[i]);
        end
        check("t5_count", 32'(word_count), 32'd2);
        end_session("t5", 1'b1, 1'b0);
        fetch(32'h0, d);
        check("t5_mem0", d, 32'hEFBE_ADDE);
        fetch(32'h4, d);
        check("t5_mem1", d, 32'h6745_2301);

        // 6: asynchronous reset mid-session
        start_session();
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        push_byte(8'h44); push_byte(8'h55); push_byte(8'h66);
        fetch(32'h0, d);
        check("t6_busy_nop", d, NOP);
        #2;
        rst_n   = 1'b0;
        prog_en = 1'b0;
        #1;
        check("t6_rst_busy", 32'(prog_busy), 32'd0);
        check("t6_rst_count", 32'(word_count), 32'd0);
        check("t6_rst_ready", 32'(byte_ready), 32'd0);
        check("t6_rst_err", 32'(prog_err), 32'd0);
        check("t6_rst_done", 32'(prog_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fetch(32'h0, d);
        check("t6_mem0", d, 32'h4433_2211);
        fetch(32'h4, d);
        check("t6_mem1", d, 32'h6745_2301);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prog_instr_memory.md
Name: prog_instr_memory

Overview:
Parametrised instruction memory with a built-in byte-stream loader. The UART receiver feeds it one byte per handshake; the block packs bytes into little-endian words and writes them at auto-incrementing addresses. The core fetches through an asynchronous read port. While a load session is active, the block stalls the core and returns NOPs on fetch. It replaces the fixed 64-word, word-write instruction memory.

Parameters:
DEPTH, 64, number of 32-bit words; must be a power of two, at least 4
NOP, 32'h00000013, word returned for out-of-range or stalled fetches
CW, $clog2(DEPTH+1), width of WORD_COUNT

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
A  in  32  core fetch byte address; A[1:0] ignored
RD  out  32  fetched instruction, combinational
PROG_EN  in  1  level; high requests or holds a load session
BYTE_VALID  in  1  loader byte valid
BYTE_DATA  in  8  loader byte
BYTE_READY  out  1  block accepts byte this cycle
PROG_BUSY  out  1  core stall; high while a session is open
PROG_DONE  out  1  one-cycle pulse when a session closes cleanly
PROG_ERR  out  1  sticky error flag for the last session
WORD_COUNT  out  CW  words written in the current or last session

Behaviour:
- Reset, asynchronous, while RST_N is low:
  - state=IDLE; word pointer=0; byte index=0; shift register=0.
  - PROG_BUSY=0, PROG_DONE=0, PROG_ERR=0, WORD_COUNT=0, BYTE_READY=0.
  - Memory array is not cleared. Simulation initial contents are NOP in every word.
- Fetch:
  - RD = memory[A[31:2]] when A[31:2] < DEPTH and PROG_BUSY=0; otherwise RD = NOP.
  - Read is combinational, with no latency.
  - A write at edge t is visible on RD after t.
- States: IDLE, LOAD, FAULT.
- IDLE:
  - PROG_EN=1 moves to LOAD next cycle.
  - On that transition: clear word pointer, byte index, WORD_COUNT and PROG_ERR.
- LOAD:
  - PROG_BUSY=1.
  - BYTE_READY = PROG_EN and (word pointer < DEPTH).
  - A byte is accepted on an edge where BYTE_VALID and BYTE_READY are both high; BYTE_VALID is ignored when BYTE_READY=0.
  - The accepted byte goes into lane [byte index] (byte 0 → bits 7:0). Byte index increments mod 4.
  - On the 4th byte, write the assembled word at that same edge to memory[word pointer]; word pointer += 1; WORD_COUNT += 1.
  - Sustained throughput is one byte per cycle, with no bubbles.
  - Overflow: a byte with BYTE_VALID=1 presented while word pointer == DEPTH → set PROG_ERR, go to FAULT. Memory is unchanged.
  - PROG_EN falls with byte index 0 → IDLE, PROG_DONE=1 for one cycle, PROG_BUSY=0 from the next cycle.
  - PROG_EN falls with byte index 1–3 → the partial word is discarded, PROG_ERR=1, IDLE. No PROG_DONE.
  - A byte presented in the same cycle PROG_EN is low is not accepted.
- FAULT:
  - BYTE_READY=0, PROG_BUSY=1.
  - Stays until PROG_EN=0, then moves to IDLE. No PROG_DONE.
- PROG_ERR and WORD_COUNT hold their values in IDLE until the next session starts.
- Reset during LOAD:
  - Session aborts immediately; outputs take their reset values.
  - Words already written stay in memory; the partial word is lost.
- PROG_DONE and PROG_ERR are never both raised for the same session end.

Test Plan:
1. Reset, then PROG_EN=1 and stream bytes 93 00 10 00 37 03 00 80 back-to-back, then drop PROG_EN.
   - memory[0]=00100093, memory[1]=80000337; WORD_COUNT=2.
   - Exactly one PROG_DONE pulse; PROG_BUSY returns to 0; a fetch at A=4 gives 80000337.
2. Fetch A=0x100 (DEPTH=64), and separately fetch any address while PROG_BUSY=1.
   - RD=00000013 in both cases; memory contents are unaffected.
3. Stream 3 bytes AA BB CC, then drop PROG_EN.
   - PROG_ERR=1, no PROG_DONE, WORD_COUNT=0; memory[0] unchanged.
   - On the next session start, PROG_ERR clears.
4. Stream 4·DEPTH bytes (incrementing pattern), then one more byte.
   - After the last full word: WORD_COUNT=DEPTH and BYTE_READY=0.
   - The extra byte causes FAULT with PROG_ERR=1; memory[0..DEPTH-1] is intact.
   - Dropping PROG_EN returns to IDLE.
5. Toggle BYTE_VALID randomly during a session.
   - Bytes are assembled only on VALID&&READY; the packed words match the byte order.
6. Assert RST_N=0 asynchronously after 6 bytes of a session (mid-clock).
   - Outputs go to reset values immediately; memory[0] holds the first word; memory[1] is unchanged.
